// File: rtl/instruction_fetch_memory_if.sv
// Fetch request/response bundle between
// the fetch stage and the instruction store.
interface instruction_fetch_memory_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic [1:0]            rsp_err;

  modport master (
    output req_valid,
    output req_addr,
    output rsp_ready,
    input  req_ready,
    input  rsp_valid,
    input  rsp_data,
    input  rsp_err
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  rsp_ready,
    output req_ready,
    output rsp_valid,
    output rsp_data,
    output rsp_err
  );
endinterface

// File: rtl/instruction_fetch_memory.sv
// Loadable instruction store: byte-addressed
// fetch, 1-cycle read, 2-entry response FIFO.
module instruction_fetch_memory #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int LOAD_AW    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load_en,
  input  logic [LOAD_AW-1:0]    load_addr,
  input  logic [DATA_WIDTH-1:0] load_data,
  instruction_fetch_memory_if.slave bus
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int SHIFT = $clog2(BYTES);

  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
    ADDR_WIDTH'(BYTES - 1);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A =
    ADDR_WIDTH'(DEPTH);
  localparam logic [LOAD_AW:0] DEPTH_L =
    (LOAD_AW + 1)'(DEPTH);

  localparam logic [1:0] ERR_OK  = 2'd0;
  localparam logic [1:0] ERR_MIS = 2'd1;
  localparam logic [1:0] ERR_OOR = 2'd2;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] word;
  logic [LOAD_AW-1:0]    idx;
  logic                  misaligned;
  logic                  oor;
  logic [1:0]            err_c;

  logic [1:0]            occ;
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [DATA_WIDTH-1:0] buf_data [2];
  logic [1:0]            buf_err  [2];

  logic accept;
  logic pop;

  assign word       = bus.req_addr >> SHIFT;
  assign idx        = word[LOAD_AW-1:0];
  assign misaligned = (bus.req_addr & ALIGN_MASK) != '0;
  assign oor        = word >= DEPTH_A;

  assign bus.req_ready = (occ != 2'd2);
  assign bus.rsp_valid = (occ != 2'd0);
  assign bus.rsp_data  = buf_data[rd_ptr];
  assign bus.rsp_err   = buf_err[rd_ptr];

  assign accept = bus.req_valid && bus.req_ready;
  assign pop    = bus.rsp_valid && bus.rsp_ready;

  // Classify the request; alignment wins over range
  always_comb begin
    err_c = ERR_OK;
    unique case (1'b1)
      misaligned:         err_c = ERR_MIS;
      (!misaligned && oor): err_c = ERR_OOR;
      default:            err_c = ERR_OK;
    endcase
  end

  // Program load; ignored in reset and past the end
  always_ff @(posedge clk) begin
    if (reset_n && load_en &&
        ({1'b0, load_addr} < DEPTH_L)) begin
      mem[load_addr] <= load_data;
    end
  end

  // Response FIFO: fill on accept, drain on pop
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      occ         <= 2'd0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      buf_data[0] <= '0;
      buf_data[1] <= '0;
      buf_err[0]  <= ERR_OK;
      buf_err[1]  <= ERR_OK;
    end else begin
      if (accept) begin
        buf_err[wr_ptr] <= err_c;
        if (err_c == ERR_OK) begin
          buf_data[wr_ptr] <= mem[idx];
        end else begin
          buf_data[wr_ptr] <= '0;
        end
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      occ <= occ + 2'(accept) - 2'(pop);
    end
  end

endmodule
